// File: rtl/passcode_digit_entry_pkg.sv
// Shared constants and types for the passcode digit-entry block.
// Optional feature macro used by this slice: DEBOUNCE_EN.
package passcode_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_BTNS = 4;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_CLR  = 3;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    DONE  = 1'b1
  } state_e;

  function automatic int cursor_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/passcode_digit_entry_if.sv
// Button inputs and code outputs of passcode_digit_entry, bundled for port connection.
// The NUM_DIGITS parameter here must match the one given to the top module.
interface passcode_digit_entry_if
  import passcode_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  localparam int CUR_W = cursor_width(NUM_DIGITS);

  logic                          i_Btn_Inc;
  logic                          i_Btn_Dec;
  logic                          i_Btn_Next;
  logic                          i_Btn_Clr;
  logic [DIGIT_W*NUM_DIGITS-1:0] o_Digits;
  logic [CUR_W-1:0]              o_Cursor;
  logic                          o_Code_Valid;
  logic                          o_Done_Pulse;

  modport master (
    output i_Btn_Inc, i_Btn_Dec, i_Btn_Next, i_Btn_Clr,
    input  o_Digits, o_Cursor, o_Code_Valid, o_Done_Pulse
  );

  modport slave (
    input  i_Btn_Inc, i_Btn_Dec, i_Btn_Next, i_Btn_Clr,
    output o_Digits, o_Cursor, o_Code_Valid, o_Done_Pulse
  );

endinterface

// File: rtl/passcode_digit_entry_button_event.sv
// Raw button to one-cycle event: 2-flop synchroniser, optional debounce filter
// (DEBOUNCE_EN), registered rising-edge pulse.
module button_event
`ifdef DEBOUNCE_EN
#(
  parameter int DEBOUNCE_LIMIT = 250000
)
`endif
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic evt_o
);

  logic sync1_q, sync2_q;
  logic lvl_q;
  logic prev_q;
  logic evt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_d;

  // The filtered level flips only after the new level has been seen DEBOUNCE_LIMIT times in a row.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
      cnt_d = '0;
      lvl_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= sync2_q;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= lvl_q;
      evt_q  <= lvl_q & ~prev_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/passcode_digit_entry.sv
// Multi-digit code entry: button events edit a cursor-selected digit until the last
// Next press freezes the code. Define DEBOUNCE_EN to filter each button.
module passcode_digit_entry
  import passcode_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_MAX      = 9,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  passcode_digit_entry_if.slave  bus
);

  localparam int CUR_W = cursor_width(NUM_DIGITS);
  localparam int CODE_W = DIGIT_W * NUM_DIGITS;
  localparam logic [CUR_W-1:0] LAST_CUR = CUR_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || DIGIT_MAX < 1 || DIGIT_MAX > 15 || DEBOUNCE_LIMIT < 1) begin : g_bad_params
    $error("passcode_digit_entry: parameter out of range");
  end

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] evt;

  assign btn_raw[BTN_INC]  = bus.i_Btn_Inc;
  assign btn_raw[BTN_DEC]  = bus.i_Btn_Dec;
  assign btn_raw[BTN_NEXT] = bus.i_Btn_Next;
  assign btn_raw[BTN_CLR]  = bus.i_Btn_Clr;

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    button_event
`ifdef DEBOUNCE_EN
      #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT))
`endif
      u_btn (
        .clk_i   (i_Clk),
        .rst_n_i (i_Rst_L),
        .btn_i   (btn_raw[b]),
        .evt_o   (evt[b])
      );
  end

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d == DIGIT_W'(DIGIT_MAX)) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
    return (d == '0) ? DIGIT_W'(DIGIT_MAX) : d - 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  logic [CODE_W-1:0]  digits_q, digits_d;
  logic               pulse_q, pulse_d;

  // Clr beats everything; Next beats digit edits; Inc together with Dec is a no-op.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    digits_d = digits_q;
    pulse_d  = 1'b0;
    if (evt[BTN_CLR]) begin
      state_d  = ENTRY;
      cursor_d = '0;
      digits_d = '0;
    end else if (state_q == ENTRY) begin
      if (evt[BTN_NEXT]) begin
        if (cursor_q == LAST_CUR) begin
          state_d = DONE;
          pulse_d = 1'b1;
        end else begin
          cursor_d = cursor_q + 1'b1;
        end
      end else if (evt[BTN_INC] ^ evt[BTN_DEC]) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (cursor_q == CUR_W'(k)) begin
            digits_d[DIGIT_W*k +: DIGIT_W] = evt[BTN_INC] ? digit_inc(digits_q[DIGIT_W*k +: DIGIT_W])
                                                          : digit_dec(digits_q[DIGIT_W*k +: DIGIT_W]);
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ENTRY;
      cursor_q <= '0;
      digits_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      digits_q <= digits_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.o_Digits     = digits_q;
  assign bus.o_Cursor     = cursor_q;
  assign bus.o_Code_Valid = (state_q == DONE);
  assign bus.o_Done_Pulse = pulse_q;

endmodule

// File: tb/tb_passcode_digit_entry.sv
// Bench for passcode_digit_entry (default build): directed scenarios with literal
// expectations plus random button traffic against a cycle-level behavioural model.
module tb_passcode_digit_entry;

  localparam int ND   = 4;
  localparam int DMAX = 9;

  logic clk;
  logic rst_n;

  passcode_digit_entry_if #(.NUM_DIGITS(ND)) bus ();

  passcode_digit_entry #(.NUM_DIGITS(ND), .DIGIT_MAX(DMAX), .DEBOUNCE_LIMIT(8)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int pulse_cnt  = 0;

  // Model state: digit values, cursor, done flag, pulse, and raw-pin history.
  int         m_dig [ND];
  int         m_cur;
  bit         m_done;
  bit         m_pulse;
  logic [3:0] hist [1:5];

  // Bit order of a button mask: 0 Inc, 1 Dec, 2 Next, 3 Clr.
  function automatic logic [3:0] pins_now();
    return {bus.i_Btn_Clr, bus.i_Btn_Next, bus.i_Btn_Dec, bus.i_Btn_Inc};
  endfunction

  function automatic logic [15:0] m_code();
    logic [15:0] c;
    c = '0;
    for (int k = 0; k < ND; k++) c[4*k +: 4] = 4'(m_dig[k]);
    return c;
  endfunction

  // A rise on the pin seen at edge E-4 (low at E-5) acts at edge E.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < ND; k++) m_dig[k] = 0;
        m_cur = 0; m_done = 0; m_pulse = 0;
        for (int k = 1; k <= 5; k++) hist[k] = '0;
      end else begin
        logic [3:0] ev;
        ev = hist[4] & ~hist[5];
        m_pulse = 0;
        if (ev[3]) begin
          for (int k = 0; k < ND; k++) m_dig[k] = 0;
          m_cur = 0; m_done = 0;
        end else if (!m_done) begin
          if (ev[2]) begin
            if (m_cur == ND - 1) begin m_done = 1; m_pulse = 1; end
            else m_cur = m_cur + 1;
          end else if (ev[0] && !ev[1]) begin
            m_dig[m_cur] = (m_dig[m_cur] + 1) % (DMAX + 1);
          end else if (ev[1] && !ev[0]) begin
            m_dig[m_cur] = (m_dig[m_cur] + DMAX) % (DMAX + 1);
          end
        end
        for (int k = 5; k > 1; k--) hist[k] = hist[k-1];
        hist[1] = pins_now();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (bus.o_Digits !== m_code() || bus.o_Cursor !== 2'(m_cur) ||
          bus.o_Code_Valid !== m_done || bus.o_Done_Pulse !== m_pulse) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got digits=%h cur=%0d valid=%b pulse=%b, want digits=%h cur=%0d valid=%b pulse=%b",
                 $time, bus.o_Digits, bus.o_Cursor, bus.o_Code_Valid, bus.o_Done_Pulse,
                 m_code(), m_cur, m_done, m_pulse);
      end
      if (bus.o_Done_Pulse === 1'b1) pulse_cnt++;
    end
  end

  task automatic check_lit(input string name, input logic [15:0] dig, input int cur, input bit valid);
    vectors++;
    if (bus.o_Digits !== dig || bus.o_Cursor !== 2'(cur) || bus.o_Code_Valid !== valid) begin
      miscompares++;
      $display("FAIL %s: got digits=%h cur=%0d valid=%b, want digits=%h cur=%0d valid=%b",
               name, bus.o_Digits, bus.o_Cursor, bus.o_Code_Valid, dig, cur, valid);
    end
  endtask

  task automatic set_pins(input logic [3:0] m);
    bus.i_Btn_Inc  = m[0];
    bus.i_Btn_Dec  = m[1];
    bus.i_Btn_Next = m[2];
    bus.i_Btn_Clr  = m[3];
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    set_pins(m);
    repeat (hold) @(negedge clk);
    set_pins(4'b0000);
    repeat (gap) @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) press(m, 1, 6);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0;
    set_pins(4'b0000);
    repeat (3) @(negedge clk);
    check_lit("reset", 16'h0000, 0, 0);
    vectors++;
    if (bus.o_Done_Pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulse: got %b want 0", bus.o_Done_Pulse);
    end
    rst_n = 1'b1;
    @(negedge clk);

    tap(4'b0001, 3);
    check_lit("three_inc", 16'h0003, 0, 0);

    tap(4'b1000, 1);
    tap(4'b0010, 1);
    check_lit("dec_wrap", 16'h0009, 0, 0);
    tap(4'b0001, 1);
    check_lit("inc_wrap", 16'h0000, 0, 0);

    tap(4'b0001, 1); tap(4'b0100, 1);
    tap(4'b0001, 2); tap(4'b0100, 1);
    tap(4'b0001, 3); tap(4'b0100, 1);
    tap(4'b0001, 4);
    check_lit("before_done", 16'h4321, 3, 0);
    p0 = pulse_cnt;
    tap(4'b0100, 1);
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL done_pulse_count: got %0d want 1", pulse_cnt - p0);
    end
    check_lit("done", 16'h4321, 3, 1);
    tap(4'b0001, 1);
    tap(4'b0100, 1);
    check_lit("frozen", 16'h4321, 3, 1);

    tap(4'b1000, 1);
    check_lit("clr_from_done", 16'h0000, 0, 0);
    tap(4'b0001, 2); tap(4'b0100, 1); tap(4'b0001, 5);
    check_lit("setup_0052", 16'h0052, 1, 0);
    tap(4'b1001, 1);
    check_lit("inc_clr", 16'h0000, 0, 0);

    tap(4'b0001, 5);
    tap(4'b0011, 1);
    check_lit("inc_dec_cancel", 16'h0005, 0, 0);
    press(4'b0001, 100, 6);
    check_lit("held_inc", 16'h0006, 0, 0);
    tap(4'b0101, 1);
    check_lit("next_with_inc", 16'h0006, 1, 0);

    tap(4'b0001, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_lit("mid_reset", 16'h0000, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] m;
      m[0] = ($urandom_range(0, 99) < 50);
      m[1] = ($urandom_range(0, 99) < 30);
      m[2] = ($urandom_range(0, 99) < 25);
      m[3] = ($urandom_range(0, 99) < 5);
      press(m, $urandom_range(1, 5), $urandom_range(0, 4));
      if ($urandom_range(0, 99) < 2) begin
        set_pins(4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    set_pins(4'b0000);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
